// File: rtl/mmwave_cfg_pkg.sv
// Shared constants for the radar configuration register bank.
// Covers register indices, commit FSM encoding and field positions inside the 64-bit words.
package mmwave_cfg_pkg;

    localparam int unsigned REG_IDX_SYS       = 0;
    localparam int unsigned REG_IDX_VCO       = 1;
    localparam int unsigned REG_IDX_AD_SAMPLE = 2;
    localparam int unsigned REG_IDX_UDP_IP    = 3;
    localparam int unsigned REG_IDX_UDP_PORT  = 4;
    localparam int unsigned REG_IDX_DSP       = 5;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Field positions inside each configuration word.
    localparam int unsigned SYS_RADAR_EN_BIT    = 0;
    localparam int unsigned SYS_TX_MASK_LSB     = 8;
    localparam int unsigned SYS_TX_MASK_W       = 4;
    localparam int unsigned VCO_FSTART_LSB      = 0;
    localparam int unsigned VCO_FSTART_W        = 32;
    localparam int unsigned VCO_SLOPE_LSB       = 32;
    localparam int unsigned VCO_SLOPE_W         = 16;
    localparam int unsigned AD_NSAMP_LSB        = 0;
    localparam int unsigned AD_NSAMP_W          = 16;
    localparam int unsigned AD_DECIM_LSB        = 16;
    localparam int unsigned AD_DECIM_W          = 8;
    localparam int unsigned UDP_IP_LSB          = 0;
    localparam int unsigned UDP_IP_W            = 32;
    localparam int unsigned UDP_PORT_DST_LSB    = 0;
    localparam int unsigned UDP_PORT_SRC_LSB    = 16;
    localparam int unsigned UDP_PORT_W          = 16;
    localparam int unsigned DSP_WINDOW_SEL_LSB  = 0;
    localparam int unsigned DSP_WINDOW_SEL_W    = 4;
    localparam int unsigned DSP_FFT_LOG2_LSB    = 8;
    localparam int unsigned DSP_FFT_LOG2_W      = 4;

endpackage

// File: rtl/mmwave_cfg_byte_merge.sv
// Combinational byte-strobe merge: each byte comes from the new word when its strobe is
// set, otherwise from the old word.
module mmwave_cfg_byte_merge
    import mmwave_cfg_pkg::*;
#(
    parameter int unsigned REG_W = 64
) (
    input  logic [REG_W-1:0]   old_i,
    input  logic [REG_W-1:0]   new_i,
    input  logic [REG_W/8-1:0] strb_i,
    output logic [REG_W-1:0]   merged_c_o
);

    localparam int unsigned STRB_W = REG_W / 8;

    for (genvar b = 0; b < STRB_W; b++) begin : g_byte
        assign merged_c_o[8*b +: 8] = strb_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end

endmodule

// File: rtl/mmwave_cfg_shadow_regbank.sv
// Radar configuration register bank: shadow registers take software writes, and the active copy
// is loaded from them only at a frame boundary after a commit.
module mmwave_cfg_shadow_regbank
    import mmwave_cfg_pkg::*;
#(
    parameter int unsigned               REG_NUM = 8,
    parameter int unsigned               REG_W   = 64,
    parameter int unsigned               IDX_W   = 3,
    parameter logic [REG_NUM*REG_W-1:0]  RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_wr_en_i,
    input  logic [IDX_W-1:0]          cfg_wr_index_i,
    input  logic [REG_W-1:0]          cfg_wr_value_i,
    input  logic [REG_W/8-1:0]        cfg_wr_strb_i,
    output logic                      cfg_wr_ack_o,
    output logic                      cfg_wr_err_o,
    input  logic                      cfg_rd_en_i,
    input  logic [IDX_W-1:0]          cfg_rd_index_i,
    input  logic                      cfg_rd_sel_active_i,
    output logic                      cfg_rd_valid_o,
    output logic [REG_W-1:0]          cfg_rd_data_o,
    input  logic                      cfg_commit_req_i,
    input  logic                      frame_sync_i,
    output logic                      cfg_commit_pending_o,
    output logic                      cfg_commit_done_o,
    output logic [REG_NUM-1:0]        cfg_dirty_o,
    output logic [REG_NUM*REG_W-1:0]  cfg_active_o
);

    localparam int unsigned STRB_W = REG_W / 8;

    logic [REG_W-1:0]   shadow_q [REG_NUM];
    logic [REG_W-1:0]   shadow_d [REG_NUM];
    logic [REG_W-1:0]   active_q [REG_NUM];
    logic [REG_W-1:0]   active_d [REG_NUM];
    logic [REG_NUM-1:0] dirty_q, dirty_d;
    logic [0:0]         state_q, state_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [REG_W-1:0]   rd_data_q, rd_data_d;

    logic               wr_in_range_c;
    logic               rd_in_range_c;
    logic               apply_c;
    logic [REG_W-1:0]   wr_old_c;
    logic [REG_W-1:0]   wr_merged_c;
    logic [REG_W-1:0]   rd_src_c;

    assign wr_in_range_c = 32'(cfg_wr_index_i) < REG_NUM;
    assign rd_in_range_c = 32'(cfg_rd_index_i) < REG_NUM;
    assign apply_c       = (state_q == ST_PENDING) && frame_sync_i;

    // Select the addressed shadow word for the merge and the addressed copy for readback.
    always_comb begin
        wr_old_c = '0;
        rd_src_c = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            if (cfg_wr_index_i == IDX_W'(i)) begin
                wr_old_c = shadow_q[i];
            end
            if (cfg_rd_index_i == IDX_W'(i)) begin
                rd_src_c = cfg_rd_sel_active_i ? active_q[i] : shadow_q[i];
            end
        end
    end

    mmwave_cfg_byte_merge #(
        .REG_W (REG_W)
    ) u_wr_merge (
        .old_i      (wr_old_c),
        .new_i      (cfg_wr_value_i),
        .strb_i     (cfg_wr_strb_i),
        .merged_c_o (wr_merged_c)
    );

    // Commit FSM: arm on request, fire on the next frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit_req_i) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_sync_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file next state; a write's dirty set overrides the apply's clear.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        dirty_d    = dirty_q;
        ack_d      = cfg_wr_en_i && wr_in_range_c;
        err_d      = cfg_wr_en_i && !wr_in_range_c;
        done_d     = apply_c;
        rd_valid_d = cfg_rd_en_i;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            if (apply_c && dirty_q[i]) begin
                active_d[i] = shadow_q[i];
                dirty_d[i]  = 1'b0;
            end
            if (cfg_wr_en_i && wr_in_range_c && (cfg_wr_index_i == IDX_W'(i))) begin
                shadow_d[i] = wr_merged_c;
                if (|cfg_wr_strb_i) begin
                    dirty_d[i] = 1'b1;
                end
            end
        end
        if (cfg_rd_en_i) begin
            rd_data_d = rd_in_range_c ? rd_src_c : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                shadow_q[i] <= RST_VAL[i*REG_W +: REG_W];
                active_q[i] <= RST_VAL[i*REG_W +: REG_W];
            end
            dirty_q    <= '0;
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            dirty_q    <= dirty_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        cfg_active_o = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            cfg_active_o[i*REG_W +: REG_W] = active_q[i];
        end
    end

    assign cfg_wr_ack_o         = ack_q;
    assign cfg_wr_err_o         = err_q;
    assign cfg_rd_valid_o       = rd_valid_q;
    assign cfg_rd_data_o        = rd_data_q;
    assign cfg_commit_pending_o = (state_q == ST_PENDING);
    assign cfg_commit_done_o    = done_q;
    assign cfg_dirty_o          = dirty_q;

endmodule

// File: tb/tb_mmwave_cfg_shadow_regbank.sv
// Directed bench for the configuration register bank, configured with six registers so that
// out-of-range indices can be exercised.
module tb_mmwave_cfg_shadow_regbank;

    localparam int unsigned REG_NUM = 6;
    localparam int unsigned REG_W   = 64;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned FLAT_W  = REG_NUM * REG_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     cfg_wr_en_i;
    logic [IDX_W-1:0]         cfg_wr_index_i;
    logic [REG_W-1:0]         cfg_wr_value_i;
    logic [REG_W/8-1:0]       cfg_wr_strb_i;
    logic                     cfg_wr_ack_o;
    logic                     cfg_wr_err_o;
    logic                     cfg_rd_en_i;
    logic [IDX_W-1:0]         cfg_rd_index_i;
    logic                     cfg_rd_sel_active_i;
    logic                     cfg_rd_valid_o;
    logic [REG_W-1:0]         cfg_rd_data_o;
    logic                     cfg_commit_req_i;
    logic                     frame_sync_i;
    logic                     cfg_commit_pending_o;
    logic                     cfg_commit_done_o;
    logic [REG_NUM-1:0]       cfg_dirty_o;
    logic [REG_NUM*REG_W-1:0] cfg_active_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmwave_cfg_shadow_regbank #(
        .REG_NUM (REG_NUM),
        .REG_W   (REG_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_wr_en_i          (cfg_wr_en_i),
        .cfg_wr_index_i       (cfg_wr_index_i),
        .cfg_wr_value_i       (cfg_wr_value_i),
        .cfg_wr_strb_i        (cfg_wr_strb_i),
        .cfg_wr_ack_o         (cfg_wr_ack_o),
        .cfg_wr_err_o         (cfg_wr_err_o),
        .cfg_rd_en_i          (cfg_rd_en_i),
        .cfg_rd_index_i       (cfg_rd_index_i),
        .cfg_rd_sel_active_i  (cfg_rd_sel_active_i),
        .cfg_rd_valid_o       (cfg_rd_valid_o),
        .cfg_rd_data_o        (cfg_rd_data_o),
        .cfg_commit_req_i     (cfg_commit_req_i),
        .frame_sync_i         (frame_sync_i),
        .cfg_commit_pending_o (cfg_commit_pending_o),
        .cfg_commit_done_o    (cfg_commit_done_o),
        .cfg_dirty_o          (cfg_dirty_o),
        .cfg_active_o         (cfg_active_o)
    );

    task automatic chk(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IDX_W-1:0] idx, input logic [63:0] val, input logic [7:0] strb);
        cfg_wr_en_i    = 1'b1;
        cfg_wr_index_i = idx;
        cfg_wr_value_i = val;
        cfg_wr_strb_i  = strb;
        tick();
        cfg_wr_en_i    = 1'b0;
    endtask

    task automatic rd(input logic [IDX_W-1:0] idx, input logic sel);
        cfg_rd_en_i         = 1'b1;
        cfg_rd_index_i      = idx;
        cfg_rd_sel_active_i = sel;
        tick();
        cfg_rd_en_i         = 1'b0;
    endtask

    initial begin
        rst_n               = 1'b0;
        cfg_wr_en_i         = 1'b0;
        cfg_wr_index_i      = '0;
        cfg_wr_value_i      = '0;
        cfg_wr_strb_i       = '0;
        cfg_rd_en_i         = 1'b0;
        cfg_rd_index_i      = '0;
        cfg_rd_sel_active_i = 1'b0;
        cfg_commit_req_i    = 1'b0;
        frame_sync_i        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_active",   cfg_active_o, '0);
        chk("rst_dirty",    FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000000));
        chk("rst_pending",  FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b0));
        chk("rst_ack",      FLAT_W'(cfg_wr_ack_o), FLAT_W'(1'b0));
        chk("rst_rd_valid", FLAT_W'(cfg_rd_valid_o), FLAT_W'(1'b0));
        chk("rst_rd_data",  FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h0));
        rst_n = 1'b1;
        tick();

        // Full write to idx 1
        wr(3'd1, 64'h0000_0000_0012_3457, 8'hFF);
        chk("wr1_ack",    FLAT_W'(cfg_wr_ack_o), FLAT_W'(1'b1));
        chk("wr1_err",    FLAT_W'(cfg_wr_err_o), FLAT_W'(1'b0));
        chk("wr1_dirty",  FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000010));
        chk("wr1_active", FLAT_W'(cfg_active_o[1*64 +: 64]), FLAT_W'(64'h0));
        tick();
        chk("wr1_ack_drop", FLAT_W'(cfg_wr_ack_o), FLAT_W'(1'b0));

        // Byte strobes on idx 2
        wr(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(3'd2, 64'h0, 8'h0F);
        chk("strb_dirty", FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000110));
        rd(3'd2, 1'b0);
        chk("strb_rd_valid", FLAT_W'(cfg_rd_valid_o), FLAT_W'(1'b1));
        chk("strb_rd_data",  FLAT_W'(cfg_rd_data_o), FLAT_W'(64'hFFFF_FFFF_0000_0000));
        tick();
        chk("rd_valid_drop", FLAT_W'(cfg_rd_valid_o), FLAT_W'(1'b0));
        chk("rd_data_hold",  FLAT_W'(cfg_rd_data_o), FLAT_W'(64'hFFFF_FFFF_0000_0000));

        // Zero strobe: ack but dirty untouched
        wr(3'd3, 64'h1234, 8'h00);
        chk("zstrb_ack",   FLAT_W'(cfg_wr_ack_o), FLAT_W'(1'b1));
        chk("zstrb_dirty", FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000110));

        // frame_sync in IDLE is ignored
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        chk("idle_sync_pending", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b0));
        chk("idle_sync_done",    FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b0));
        chk("idle_sync_active",  cfg_active_o, '0);
        chk("idle_sync_dirty",   FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000110));

        // Commit, frame_sync five cycles later
        cfg_commit_req_i = 1'b1;
        tick();
        cfg_commit_req_i = 1'b0;
        chk("commit_pending0", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b1));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("commit_pending_wait", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b1));
            chk("commit_active_wait",  FLAT_W'(cfg_active_o[1*64 +: 64]), FLAT_W'(64'h0));
        end
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        chk("apply_pending", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b0));
        chk("apply_done",    FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b1));
        chk("apply_act1",    FLAT_W'(cfg_active_o[1*64 +: 64]), FLAT_W'(64'h0000_0000_0012_3457));
        chk("apply_act2",    FLAT_W'(cfg_active_o[2*64 +: 64]), FLAT_W'(64'hFFFF_FFFF_0000_0000));
        chk("apply_act3",    FLAT_W'(cfg_active_o[3*64 +: 64]), FLAT_W'(64'h0));
        chk("apply_dirty",   FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000000));
        rd(3'd1, 1'b1);
        chk("apply_done_drop", FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b0));
        chk("apply_rd_act1",   FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h0000_0000_0012_3457));

        // Out-of-range write and read
        wr(3'd7, 64'hDEAD_BEEF, 8'hFF);
        chk("oor_err",   FLAT_W'(cfg_wr_err_o), FLAT_W'(1'b1));
        chk("oor_ack",   FLAT_W'(cfg_wr_ack_o), FLAT_W'(1'b0));
        chk("oor_dirty", FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000000));
        rd(3'd7, 1'b0);
        chk("oor_err_drop", FLAT_W'(cfg_wr_err_o), FLAT_W'(1'b0));
        chk("oor_rd_valid", FLAT_W'(cfg_rd_valid_o), FLAT_W'(1'b1));
        chk("oor_rd_data",  FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h0));
        rd(3'd6, 1'b1);
        chk("oor6_rd_data", FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h0));

        // Write colliding with an apply edge
        wr(3'd0, 64'h5, 8'hFF);
        cfg_commit_req_i = 1'b1;
        tick();
        cfg_commit_req_i = 1'b0;
        chk("coll_pending", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b1));
        frame_sync_i = 1'b1;
        wr(3'd0, 64'hA, 8'hFF);
        frame_sync_i = 1'b0;
        chk("coll_act0",  FLAT_W'(cfg_active_o[0*64 +: 64]), FLAT_W'(64'h5));
        chk("coll_dirty", FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000001));
        chk("coll_done",  FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b1));
        rd(3'd0, 1'b0);
        chk("coll_rd_shadow", FLAT_W'(cfg_rd_data_o), FLAT_W'(64'hA));
        rd(3'd0, 1'b1);
        chk("coll_rd_active", FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h5));

        // commit_req with frame_sync in IDLE: arm only
        wr(3'd4, 64'h77, 8'hFF);
        cfg_commit_req_i = 1'b1;
        frame_sync_i     = 1'b1;
        tick();
        cfg_commit_req_i = 1'b0;
        frame_sync_i     = 1'b0;
        chk("both_pending", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b1));
        chk("both_done",    FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b0));
        chk("both_act4",    FLAT_W'(cfg_active_o[4*64 +: 64]), FLAT_W'(64'h0));
        tick();
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        chk("both_apply_done",  FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b1));
        chk("both_apply_act4",  FLAT_W'(cfg_active_o[4*64 +: 64]), FLAT_W'(64'h77));
        chk("both_apply_act0",  FLAT_W'(cfg_active_o[0*64 +: 64]), FLAT_W'(64'hA));
        chk("both_apply_dirty", FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000000));

        // Reset while pending
        wr(3'd5, 64'h99, 8'hFF);
        cfg_commit_req_i = 1'b1;
        tick();
        cfg_commit_req_i = 1'b0;
        chk("rstp_pending_before", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstp_pending", FLAT_W'(cfg_commit_pending_o), FLAT_W'(1'b0));
        chk("rstp_active",  cfg_active_o, '0);
        chk("rstp_dirty",   FLAT_W'(cfg_dirty_o), FLAT_W'(6'b000000));
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstp_done", FLAT_W'(cfg_commit_done_o), FLAT_W'(1'b0));
        rd(3'd5, 1'b0);
        chk("rstp_rd_shadow5",   FLAT_W'(cfg_rd_data_o), FLAT_W'(64'h0));
        chk("rstp_active_after", cfg_active_o, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmwave_cfg_shadow_regbank.md
Name: mmwave_cfg_shadow_regbank

Overview:
Parametrised successor to the radar configuration register file. Software-side writes (from the UART/Ethernet command decoder) land in shadow registers with byte enables. The active copy that drives VCO/ADC/UDP logic is updated only at a frame boundary after an explicit commit, so chirp parameters never change mid-frame. Adds per-register dirty tracking, range-checked write acknowledge/error and one-cycle readback of shadow or active values.

Parameters:
REG_NUM, 8, number of configuration registers (2..32)
REG_W, 64, register width in bits; must be a multiple of 8
IDX_W, 3, index width; must satisfy 2**IDX_W >= REG_NUM
RST_VAL, {REG_NUM*REG_W{1'b0}}, flat reset value for both shadow and active copies; register i occupies bits [i*REG_W +: REG_W]

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
cfg_wr_en_i  input  1  single-cycle write strobe
cfg_wr_index_i  input  IDX_W  target register index
cfg_wr_value_i  input  REG_W  write data
cfg_wr_strb_i  input  REG_W/8  byte enables; bit b covers data bits [8b+7:8b]
cfg_wr_ack_o  output  1  pulse: write accepted
cfg_wr_err_o  output  1  pulse: write rejected (index >= REG_NUM)
cfg_rd_en_i  input  1  read strobe
cfg_rd_index_i  input  IDX_W  read index
cfg_rd_sel_active_i  input  1  read source: 1 = active copy, 0 = shadow copy
cfg_rd_valid_o  output  1  read data valid pulse
cfg_rd_data_o  output  REG_W  read data
cfg_commit_req_i  input  1  request to apply shadow to active at the next frame boundary
frame_sync_i  input  1  single-cycle frame-boundary pulse from the chirp timer
cfg_commit_pending_o  output  1  commit armed and waiting for frame_sync_i
cfg_commit_done_o  output  1  pulse: active copy updated
cfg_dirty_o  output  REG_NUM  shadow differs from active (written since last apply)
cfg_active_o  output  REG_NUM*REG_W  flat active configuration; register i at [i*REG_W +: REG_W]

Behaviour:
- Reset values: shadow = active = RST_VAL; dirty = 0; all pulses = 0; rd_data = 0; FSM in IDLE.
- Write:
  - On the wr_en edge with index < REG_NUM, shadow bytes with strb=1 are updated; the other bytes are held.
  - dirty[index] is set if any strb bit is 1.
  - ack is high exactly one cycle later.
  - With index >= REG_NUM: no state change; err is high one cycle later; ack stays 0.
  - wr_en with strb = 0 and a valid index: ack is asserted, dirty is unchanged.
- Read:
  - Registered with 1-cycle latency.
  - rd_data reflects the selected copy as it was before that edge's writes.
  - An out-of-range index returns 0 with rd_valid still asserted.
  - rd_data holds its value when rd_en = 0.
- Commit FSM has two states, IDLE and PENDING; cfg_commit_pending_o = (state == PENDING).
  - IDLE -> PENDING on commit_req.
  - In IDLE, frame_sync is ignored.
  - In PENDING, commit_req is ignored (no queueing).
  - PENDING -> IDLE on frame_sync. On that edge, every register with dirty = 1 is copied shadow -> active and its dirty bit is cleared. done is high the following cycle for one cycle.
  - commit_req and frame_sync in the same cycle while in IDLE: go to PENDING only; the apply waits for the next frame_sync.
- Write on the same edge as an apply:
  - Active receives the pre-write shadow value.
  - The shadow takes the new data.
  - dirty[index] ends at 1, because the set has priority over the clear.
- cfg_active_o changes only on apply edges and on reset.
- Reset asserted mid-PENDING: FSM returns to IDLE and all registers return to RST_VAL immediately (asynchronous); no done pulse is generated.

Decomposition:
- Shared package mmwave_cfg_pkg holds:
  - register index constants (SYS=0, VCO=1, AD_SAMPLE=2, UDP_IP=3, UDP_PORT=4, DSP=5);
  - the FSM state encoding;
  - the field bit-position constants used by the field-decode wrapper.
- Natural sub-module: mmwave_cfg_byte_merge, a combinational strobe merge of old/new REG_W words, instantiated once per write path.

Test Plan:
- Reset with RST_VAL = 0 -> cfg_active_o = 0, dirty = 0, pending = 0. Write idx 1 = 64'h0000_0000_0012_3457 with strb = 8'hFF -> ack after 1 cycle, dirty = 8'b0000_0010, active still 0.
- Byte strobes: shadow idx 2 = 64'hFFFF_FFFF_FFFF_FFFF; write 64'h0 with strb = 8'h0F -> shadow read (sel = 0) = 64'hFFFF_FFFF_0000_0000 one cycle after rd_en.
- Commit: commit_req, then frame_sync 5 cycles later -> pending high for those cycles. Active idx 1 = 64'h...3457 on the sync edge, done pulse 1 cycle later, dirty = 0, active readback matches.
- Out-of-range: REG_NUM = 6, write idx 7 -> err pulse, ack = 0, no dirty bit set. Read idx 7 -> rd_valid, data = 0.
- Collision: in PENDING, write idx 0 = 64'hA on the same edge as frame_sync while shadow idx 0 = 64'h5 is dirty -> active idx 0 = 64'h5, shadow = 64'hA, dirty[0] = 1.
- Corner cases:
  - frame_sync in IDLE -> no change.
  - commit_req together with frame_sync in IDLE -> pending only, apply on the next sync.
  - rst_n dropped while pending -> immediate return to RST_VAL, no done pulse.
